// File: rtl/iram_init_loader_pkg.sv
// Shared widths and FSM state encoding for the instruction RAM init loader.
package iram_init_loader_pkg;
   localparam int ADDR_W    = 9;
   localparam int DATA_W    = 9;
   localparam int MAX_WORDS = 512;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      DONE,
      ERROR
   } state_t;
endpackage

// File: rtl/iram_init_loader_if.sv
// Source stream, control and instruction RAM init port of the loader.
interface iram_init_loader_if;
   import iram_init_loader_pkg::*;

   logic              START;
   logic              SRC_VALID;
   logic [DATA_W-1:0] SRC_DATA;
   logic              SRC_READY;
   logic [ADDR_W-1:0] INITADDR;
   logic [DATA_W-1:0] INITDATA;
   logic              WENABLE;
   logic              CORE_HOLD;
   logic              INIT_DONE;
   logic              INIT_ERR;

   // Loader side
   modport slave (
      input  START, SRC_VALID, SRC_DATA,
      output SRC_READY, INITADDR, INITDATA, WENABLE, CORE_HOLD, INIT_DONE, INIT_ERR
   );

   // Source / supervisor side
   modport master (
      output START, SRC_VALID, SRC_DATA,
      input  SRC_READY, INITADDR, INITDATA, WENABLE, CORE_HOLD, INIT_DONE, INIT_ERR
   );
endinterface

// File: rtl/iram_init_loader.sv
// Streams INIT_WORDS words into the instruction RAM init port, optionally
// verifies a trailing mod-512 checksum, and releases the core only on success.
//
// state | meaning
// IDLE  | after reset, waiting for START, core held
// LOAD  | accepting data words, one RAM write per accepted word
// CHECK | waiting for the checksum word (never written to RAM)
// DONE  | load good, core released
// ERROR | checksum mismatch, core held until a new run
module iram_init_loader
   import iram_init_loader_pkg::*;
#(
   parameter int INIT_WORDS = 512,
   parameter int CHECK_EN   = 1
) (
   input logic               RWCLK,
   input logic               RESET,
   iram_init_loader_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INIT_WORDS - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] acc;
   logic              accept;

   assign accept = bus.SRC_VALID && bus.SRC_READY;

   always_ff @(posedge RWCLK or posedge RESET) begin
      if (RESET) begin
         state         <= IDLE;
         cnt           <= '0;
         acc           <= '0;
         bus.INITADDR  <= '0;
         bus.INITDATA  <= '0;
         bus.WENABLE   <= 1'b0;
         bus.SRC_READY <= 1'b0;
         bus.CORE_HOLD <= 1'b1;
         bus.INIT_DONE <= 1'b0;
         bus.INIT_ERR  <= 1'b0;
      end else begin
         bus.WENABLE <= 1'b0;
         unique case (state)
            IDLE, DONE, ERROR: begin
               if (bus.START) begin
                  state         <= LOAD;
                  cnt           <= '0;
                  acc           <= '0;
                  bus.SRC_READY <= 1'b1;
                  bus.CORE_HOLD <= 1'b1;
                  bus.INIT_DONE <= 1'b0;
                  bus.INIT_ERR  <= 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  bus.WENABLE  <= 1'b1;
                  bus.INITADDR <= cnt;
                  bus.INITDATA <= bus.SRC_DATA;
                  acc          <= acc + bus.SRC_DATA;
                  cnt          <= cnt + 1'b1;
                  if (cnt == LAST_ADDR) begin
                     if (CHECK_EN != 0) begin
                        state <= CHECK;
                     end else begin
                        state         <= DONE;
                        bus.SRC_READY <= 1'b0;
                        bus.CORE_HOLD <= 1'b0;
                        bus.INIT_DONE <= 1'b1;
                     end
                  end
               end
            end
            CHECK: begin
               if (accept) begin
                  bus.SRC_READY <= 1'b0;
                  if (bus.SRC_DATA == acc) begin
                     state         <= DONE;
                     bus.CORE_HOLD <= 1'b0;
                     bus.INIT_DONE <= 1'b1;
                  end else begin
                     state        <= ERROR;
                     bus.INIT_ERR <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iram_init_loader.sv
// Directed bench for iram_init_loader: full load, bad checksum, stalls,
// mid-load reset and the no-checksum single-word configuration.
module tb_iram_init_loader;
   import iram_init_loader_pkg::*;

   logic clk = 1'b0;
   logic rst_full, rst_small, rst_one;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   iram_init_loader_if bus_full ();
   iram_init_loader_if bus_small ();
   iram_init_loader_if bus_one ();

   iram_init_loader #(.INIT_WORDS(512), .CHECK_EN(1)) dut_full (
      .RWCLK(clk), .RESET(rst_full), .bus(bus_full)
   );
   iram_init_loader #(.INIT_WORDS(4), .CHECK_EN(1)) dut_small (
      .RWCLK(clk), .RESET(rst_small), .bus(bus_small)
   );
   iram_init_loader #(.INIT_WORDS(1), .CHECK_EN(0)) dut_one (
      .RWCLK(clk), .RESET(rst_one), .bus(bus_one)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // bad checksum run: sum of data is 0x005, checksum word 0x006
   logic [8:0] bad_data [5] = '{9'h1FF, 9'h001, 9'h002, 9'h003, 9'h006};

   // stall run, one entry per cycle after START
   logic       st_valid [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 0};
   logic [8:0] st_data  [9] = '{9'h010, 9'h155, 9'h155, 9'h011, 9'h012, 9'h155, 9'h013, 9'h046, 9'h155};
   logic       st_start [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
   logic       exp_we   [9] = '{0, 1, 0, 0, 1, 1, 0, 1, 0};
   logic [8:0] exp_addr [9] = '{9'd3, 9'd0, 9'd0, 9'd0, 9'd1, 9'd2, 9'd2, 9'd3, 9'd3};
   logic [8:0] exp_dat  [9] = '{9'h003, 9'h010, 9'h010, 9'h010, 9'h011, 9'h012, 9'h012, 9'h013, 9'h013};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_full = 1'b1;  rst_small = 1'b1;  rst_one = 1'b1;
      bus_full.START = 1'b0;  bus_full.SRC_VALID = 1'b0;  bus_full.SRC_DATA = '0;
      bus_small.START = 1'b0; bus_small.SRC_VALID = 1'b0; bus_small.SRC_DATA = '0;
      bus_one.START = 1'b0;   bus_one.SRC_VALID = 1'b0;   bus_one.SRC_DATA = '0;
      tick();
      tick();
      rst_full = 1'b0;  rst_small = 1'b0;  rst_one = 1'b0;

      // reset values
      smp();
      check("rst_ready", bus_full.SRC_READY, 1'b0);
      check("rst_hold",  bus_full.CORE_HOLD, 1'b1);
      check("rst_done",  bus_full.INIT_DONE, 1'b0);
      check("rst_err",   bus_full.INIT_ERR,  1'b0);
      check("rst_we",    bus_full.WENABLE,   1'b0);
      check("rst_addr",  bus_full.INITADDR,  9'd0);
      check("rst_data",  bus_full.INITDATA,  9'd0);

      // full 512-word load, data = address, checksum 0x100
      tick();
      bus_full.START = 1'b1;
      tick();
      bus_full.START = 1'b0;
      for (int i = 0; i <= 513; i++) begin
         if (i < 512) begin
            bus_full.SRC_VALID = 1'b1;
            bus_full.SRC_DATA  = 9'(i);
         end else if (i == 512) begin
            bus_full.SRC_VALID = 1'b1;
            bus_full.SRC_DATA  = 9'h100;
         end else begin
            bus_full.SRC_VALID = 1'b0;
         end
         smp();
         if (i == 0) begin
            check("full_ready0", bus_full.SRC_READY, 1'b1);
            check("full_we0",    bus_full.WENABLE,   1'b0);
         end else if (i <= 512) begin
            check($sformatf("full_we%0d", i),   bus_full.WENABLE,  1'b1);
            check($sformatf("full_addr%0d", i), bus_full.INITADDR, 16'(i - 1));
            check($sformatf("full_data%0d", i), bus_full.INITDATA, 16'(i - 1));
         end else begin
            check("full_we_end",   bus_full.WENABLE,   1'b0);
            check("full_done",     bus_full.INIT_DONE, 1'b1);
            check("full_hold",     bus_full.CORE_HOLD, 1'b0);
            check("full_ready",    bus_full.SRC_READY, 1'b0);
            check("full_addr_hold", bus_full.INITADDR, 9'd511);
         end
         if (i == 512) begin
            check("full_chk_hold",  bus_full.CORE_HOLD, 1'b1);
            check("full_chk_ready", bus_full.SRC_READY, 1'b1);
         end
         tick();
      end

      // restart from DONE, reset after 100 writes
      bus_full.START = 1'b1;
      tick();
      bus_full.START = 1'b0;
      for (int i = 0; i <= 100; i++) begin
         bus_full.SRC_VALID = 1'b1;
         bus_full.SRC_DATA  = 9'(i);
         smp();
         if (i == 100) begin
            check("mid_we100",   bus_full.WENABLE,  1'b1);
            check("mid_addr100", bus_full.INITADDR, 9'd99);
         end else begin
            tick();
         end
      end
      #1 rst_full = 1'b1;
      #1;
      check("arst_we",    bus_full.WENABLE,   1'b0);
      check("arst_addr",  bus_full.INITADDR,  9'd0);
      check("arst_data",  bus_full.INITDATA,  9'd0);
      check("arst_ready", bus_full.SRC_READY, 1'b0);
      check("arst_hold",  bus_full.CORE_HOLD, 1'b1);
      check("arst_done",  bus_full.INIT_DONE, 1'b0);
      tick();
      rst_full = 1'b0;
      bus_full.SRC_DATA = 9'h055;
      for (int i = 0; i < 3; i++) begin
         smp();
         check($sformatf("post_rst_we%0d", i),    bus_full.WENABLE,   1'b0);
         check($sformatf("post_rst_ready%0d", i), bus_full.SRC_READY, 1'b0);
         tick();
      end
      bus_full.START = 1'b1;
      tick();
      bus_full.START    = 1'b0;
      bus_full.SRC_DATA = 9'h0A0;
      smp();
      check("restart_ready", bus_full.SRC_READY, 1'b1);
      tick();
      bus_full.SRC_DATA = 9'h0A1;
      smp();
      check("restart_we0",   bus_full.WENABLE,  1'b1);
      check("restart_addr0", bus_full.INITADDR, 9'd0);
      check("restart_data0", bus_full.INITDATA, 9'h0A0);
      tick();
      bus_full.SRC_VALID = 1'b0;
      smp();
      check("restart_addr1", bus_full.INITADDR, 9'd1);
      check("restart_data1", bus_full.INITDATA, 9'h0A1);
      tick();

      // bad checksum, 4 words
      bus_small.START = 1'b1;
      tick();
      bus_small.START = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         bus_small.SRC_VALID = (i < 5);
         if (i < 5) bus_small.SRC_DATA = bad_data[i];
         smp();
         if (i >= 1 && i <= 4) begin
            check($sformatf("bad_we%0d", i),   bus_small.WENABLE,  1'b1);
            check($sformatf("bad_addr%0d", i), bus_small.INITADDR, 16'(i - 1));
            check($sformatf("bad_data%0d", i), bus_small.INITDATA, 16'(bad_data[i - 1]));
         end
         if (i == 4) begin
            check("bad_chk_ready", bus_small.SRC_READY, 1'b1);
            check("bad_chk_hold",  bus_small.CORE_HOLD, 1'b1);
         end
         if (i == 5) begin
            check("bad_no_write", bus_small.WENABLE,   1'b0);
            check("bad_err",      bus_small.INIT_ERR,  1'b1);
            check("bad_hold",     bus_small.CORE_HOLD, 1'b1);
            check("bad_done",     bus_small.INIT_DONE, 1'b0);
            check("bad_ready",    bus_small.SRC_READY, 1'b0);
         end
         tick();
      end

      // stalls, restarting from ERROR; START with checksum acceptance ignored
      bus_small.START = 1'b1;
      tick();
      bus_small.START = 1'b0;
      for (int j = 0; j < 9; j++) begin
         bus_small.SRC_VALID = st_valid[j];
         bus_small.SRC_DATA  = st_data[j];
         bus_small.START     = st_start[j];
         smp();
         check($sformatf("stall_we%0d", j),   bus_small.WENABLE,  exp_we[j]);
         check($sformatf("stall_addr%0d", j), bus_small.INITADDR, exp_addr[j]);
         check($sformatf("stall_data%0d", j), bus_small.INITDATA, exp_dat[j]);
         if (j == 0) check("stall_err_clr", bus_small.INIT_ERR, 1'b0);
         if (j == 1) check("stall_ready",   bus_small.SRC_READY, 1'b1);
         if (j == 8) begin
            check("stall_done", bus_small.INIT_DONE, 1'b1);
            check("stall_hold", bus_small.CORE_HOLD, 1'b0);
            check("stall_err",  bus_small.INIT_ERR,  1'b0);
         end
         tick();
      end
      bus_small.SRC_VALID = 1'b0;

      // no checksum, one word, START held through LOAD
      bus_one.START = 1'b1;
      tick();
      bus_one.SRC_VALID = 1'b1;
      bus_one.SRC_DATA  = 9'h0AA;
      smp();
      check("one_ready", bus_one.SRC_READY, 1'b1);
      check("one_we0",   bus_one.WENABLE,   1'b0);
      tick();
      bus_one.START     = 1'b0;
      bus_one.SRC_VALID = 1'b0;
      smp();
      check("one_we",    bus_one.WENABLE,   1'b1);
      check("one_addr",  bus_one.INITADDR,  9'd0);
      check("one_data",  bus_one.INITDATA,  9'h0AA);
      check("one_done",  bus_one.INIT_DONE, 1'b1);
      check("one_hold",  bus_one.CORE_HOLD, 1'b0);
      check("one_rdy_lo", bus_one.SRC_READY, 1'b0);
      tick();
      smp();
      check("one_we_end",  bus_one.WENABLE,   1'b0);
      check("one_done_st", bus_one.INIT_DONE, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iram_init_loader.md
IRAM_INIT_LOADER -- requirements
Module: iram_init_loader

Interface
REQ-001 SHALL provide parameter INIT_WORDS, default 512: number of instruction words loaded per run (1..512).
REQ-002 SHALL provide parameter CHECK_EN, default 1: 1 = a checksum word follows the data, 0 = no checksum word.
REQ-003 RWCLK  in  1  single clock for all logic; rising edge active.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 START  in  1  one-cycle request to begin a load run.
REQ-006 SRC_VALID  in  1  source word available.
REQ-007 SRC_DATA  in  9  source word.
REQ-008 SRC_READY  out  1  loader accepts SRC_DATA this cycle.
REQ-009 INITADDR  out  9  write address to the instruction RAM init port.
REQ-010 INITDATA  out  9  write data to the instruction RAM init port.
REQ-011 WENABLE  out  1  active-high write strobe to the instruction RAM init port.
REQ-012 CORE_HOLD  out  1  holds the sequencer core in reset and blocks instruction reads while high.
REQ-013 INIT_DONE  out  1  load completed successfully.
REQ-014 INIT_ERR  out  1  checksum mismatch on the last run.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CHECK, DONE, ERROR.
REQ-016 Transitions:
- IDLE -> LOAD on START; clears the word counter and checksum accumulator.
- LOAD -> CHECK after INIT_WORDS accepted words when CHECK_EN=1; LOAD -> DONE when CHECK_EN=0.
- CHECK -> DONE on accepting a checksum word equal to the accumulator; CHECK -> ERROR on a mismatch.
- DONE or ERROR -> LOAD on START, starting a fresh run.
REQ-017 SRC_READY SHALL be high only in LOAD and CHECK, with no dependency on SRC_VALID.
REQ-018 A word SHALL be accepted only in a cycle with SRC_VALID=1 and SRC_READY=1; SRC_VALID low stalls the loader indefinitely with no timeout.
REQ-019 Each word accepted in LOAD SHALL produce registered outputs on the next cycle: WENABLE=1 for exactly one cycle, INITADDR = counter value at acceptance, INITDATA = accepted word. Latency is 1 cycle.
REQ-020 The counter SHALL start at 0 and increment by 1 per accepted LOAD word; addresses are strictly sequential with no wrap within a run.
REQ-021 Back-to-back accepted words SHALL produce back-to-back write cycles at full rate of one word per clock.
REQ-022 The accumulator SHALL be the sum of all LOAD data words, modulo 512 (9-bit wrap, carry discarded).
REQ-023 The checksum word SHALL NOT be written to RAM; WENABLE stays 0 in CHECK.
REQ-024 CORE_HOLD SHALL be 1 in IDLE, LOAD, CHECK and ERROR, and 0 only in DONE.
REQ-025 INIT_DONE SHALL be 1 only in DONE; INIT_ERR SHALL be 1 only in ERROR.
REQ-026 START in LOAD or CHECK SHALL be ignored.
REQ-027 START arriving in the same cycle as the final LOAD or CHECK acceptance SHALL be ignored; the run completes normally.
REQ-028 When not writing, INITADDR and INITDATA SHALL hold their last values and WENABLE SHALL be 0.

Reset
REQ-029 RESET SHALL asynchronously force:
- state IDLE; counter 0; accumulator 0;
- INITADDR 0; INITDATA 0; WENABLE 0; SRC_READY 0;
- CORE_HOLD 1; INIT_DONE 0; INIT_ERR 0.
REQ-030 RESET asserted mid-LOAD SHALL abort the run immediately; the partially written RAM content is not invalidated, and CORE_HOLD remains 1 until a later run reaches DONE.
REQ-031 After RESET deasserts, no write SHALL occur until START is received.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state enumeration;
- ADDR_W=9, DATA_W=9, MAX_WORDS=512.
REQ-033 SHALL be a single module with no sub-module; the datapath is the counter, accumulator and output registers.

Verification
REQ-034 Full load, CHECK_EN=1, INIT_WORDS=512: source streams data = addr[8:0] continuously, then checksum 0x100 -> 512 one-cycle writes at addresses 0..511 with INITDATA=address; INIT_DONE=1; CORE_HOLD falls one cycle after the checksum is accepted.
REQ-035 Bad checksum, INIT_WORDS=4: data 0x1FF, 0x001, 0x002, 0x003 (sum mod 512 = 0x005), checksum 0x006 -> ERROR; INIT_ERR=1; CORE_HOLD=1; no write during CHECK.
REQ-036 Stalls, INIT_WORDS=4: SRC_VALID toggled 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0..3, each one cycle after its acceptance; no writes in stall cycles.
REQ-037 Reset mid-load: RESET pulsed after 100 writes -> all outputs at reset values asynchronously; a subsequent START restarts writes at address 0.
REQ-038 CHECK_EN=0, INIT_WORDS=1: START, then one word 0x0AA -> a single write at address 0 with data 0x0AA, then DONE; START held high throughout LOAD is ignored.
